shadow_bank_loader: RTL and testbench

- Parametrised successor to the per-field control combiner.
- Accepts a stream of WIDTH-bit words from a host pipe endpoint into FIELDS shadow banks of CHANNELS entries each (amp, offset, phaseword).
- On a commit request, atomically transfers all shadow banks to the active banks at the next frame boundary, so the oscillator array never sees a half-loaded parameter set.
- Sits between the host pipe-in endpoints and the oscillator array.

---
 rtl/shadow_bank_pkg.sv | 27 ++
 rtl/shadow_bank_field.sv | 133 +++++++++++++
 rtl/shadow_bank_loader.sv | 132 +++++++++++++
 tb/tb_shadow_bank_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shadow_bank_pkg
// Description : Shared constants and types for the shadow bank loader.
//               Default geometry, field index constants and the commit FSM
//               state type.
//               The optional checksum feature is controlled by the macro
//               SHADOW_BANK_CHECKSUM_EN (see shadow_bank_field).
// Revision    : 1.0 - initial release
// ============================================================================
package shadow_bank_pkg;

    localparam int DEF_CHANNELS = 64;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_FIELDS   = 3;

    localparam int FIELD_AMP    = 0;
    localparam int FIELD_OFFSET = 1;
    localparam int FIELD_PHASE  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } commit_state_t;

endpackage : shadow_bank_pkg
`default_nettype wire

// File: rtl/shadow_bank_field.sv
`default_nettype none
// ============================================================================
// Module      : shadow_bank_field
// Description : One shadow parameter bank. Holds CHANNELS entries of WIDTH
//               bits that are loaded sequentially from a write stream, with
//               an address counter, full/overflow flags and an optional
//               running checksum (macro SHADOW_BANK_CHECKSUM_EN).
// Ports       : clk, reset_n       - clock, synchronous active-low reset
//               wr_en, wr_data     - write strobe (already field-qualified)
//               load_start         - restart address counter, clear flags
//               full, overflow     - bank complete / write dropped (sticky)
//               checksum           - wrapping sum of accepted words (or 0)
//               shadow_flat        - all entries, channel c at c*WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module shadow_bank_field
    import shadow_bank_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      load_start,
    output logic                      full,
    output logic                      overflow,
    output logic [WIDTH-1:0]          checksum,
    output logic [CHANNELS*WIDTH-1:0] shadow_flat
);

    localparam int              c_AW   = $clog2(CHANNELS);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(CHANNELS - 1);

    logic [c_AW-1:0]  r_addr_q;
    logic [c_AW-1:0]  w_addr_d;
    logic             r_full_q;
    logic             w_full_d;
    logic             r_ovf_q;
    logic             w_ovf_d;
    logic             w_accept;
    logic [c_AW-1:0]  w_wr_addr;
    logic [WIDTH-1:0] r_shadow_q [CHANNELS];

    // load_start is applied before the write in the same cycle, so the
    // write sees a cleared counter and flags.
    always_comb begin
        w_addr_d  = r_addr_q;
        w_full_d  = r_full_q;
        w_ovf_d   = r_ovf_q;
        w_accept  = 1'b0;
        w_wr_addr = r_addr_q;

        if (load_start) begin
            w_addr_d  = '0;
            w_full_d  = 1'b0;
            w_ovf_d   = 1'b0;
            w_wr_addr = '0;
        end

        if (wr_en) begin
            if (w_full_d) begin
                w_ovf_d = 1'b1;
            end else begin
                w_accept = 1'b1;
                if (w_wr_addr == c_LAST) begin
                    w_addr_d = '0;
                    w_full_d = 1'b1;
                end else begin
                    w_addr_d = w_wr_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr_q <= '0;
            r_full_q <= 1'b0;
            r_ovf_q  <= 1'b0;
        end else begin
            r_addr_q <= w_addr_d;
            r_full_q <= w_full_d;
            r_ovf_q  <= w_ovf_d;
        end
    end

    // Shadow storage is only cleared by reset; load_start leaves old
    // contents in place so a partial load keeps unwritten entries.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow_q[i] <= '0;
            end
        end else if (w_accept) begin
            r_shadow_q[w_wr_addr] <= wr_data;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_flat
        assign shadow_flat[c*WIDTH +: WIDTH] = r_shadow_q[c];
    end

`ifdef SHADOW_BANK_CHECKSUM_EN
    logic [WIDTH-1:0] r_sum_q;
    logic [WIDTH-1:0] w_sum_d;

    always_comb begin
        w_sum_d = load_start ? '0 : r_sum_q;
        if (w_accept) begin
            w_sum_d = w_sum_d + wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sum_q <= '0;
        end else begin
            r_sum_q <= w_sum_d;
        end
    end

    assign checksum = r_sum_q;
`else
    assign checksum = '0;
`endif

    assign full     = r_full_q;
    assign overflow = r_ovf_q;

endmodule : shadow_bank_field
`default_nettype wire

// File: rtl/shadow_bank_loader.sv
`default_nettype none
// ============================================================================
// Module      : shadow_bank_loader
// Description : Streams host words into FIELDS shadow banks and, on a commit
//               request, copies every shadow bank into the active banks at
//               the next frame boundary in a single clock edge.
//               Optional per-field checksum: macro SHADOW_BANK_CHECKSUM_EN.
// Ports       : clk, reset_n            - clock, synchronous active-low reset
//               wr_en/wr_field/wr_data  - write stream into selected field
//               load_start              - restart all field address counters
//               commit_req, frame_sync  - commit request / frame boundary
//               commit_pending          - commit armed, awaiting frame_sync
//               commit_done             - pulse alongside new active_out
//               load_full/load_overflow - per-field status flags
//               load_checksum           - per-field checksum (flat)
//               active_out              - active banks, (f*CHANNELS+c)*WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module shadow_bank_loader
    import shadow_bank_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int FIELDS   = DEF_FIELDS,
    localparam int FIELD_W  = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             wr_en,
    input  logic [FIELD_W-1:0]               wr_field,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             load_start,
    input  logic                             commit_req,
    input  logic                             frame_sync,
    output logic                             commit_pending,
    output logic                             commit_done,
    output logic [FIELDS-1:0]                load_full,
    output logic [FIELDS-1:0]                load_overflow,
    output logic [FIELDS*WIDTH-1:0]          load_checksum,
    output logic [FIELDS*CHANNELS*WIDTH-1:0] active_out
);

    localparam int c_BANK_W = CHANNELS * WIDTH;
    localparam int c_ALL_W  = FIELDS * c_BANK_W;

    commit_state_t      r_state_q;
    commit_state_t      w_state_d;
    logic               w_commit;
    logic               r_done_q;
    logic [c_ALL_W-1:0] w_shadow_flat;
    logic [c_ALL_W-1:0] r_active_q;
    logic [c_ALL_W-1:0] w_active_d;

    // A wr_field value of FIELDS or more matches no bank and is ignored.
    for (genvar f = 0; f < FIELDS; f++) begin : g_field
        logic w_sel;
        assign w_sel = wr_en && (int'(wr_field) == f);

        shadow_bank_field #(
            .CHANNELS (CHANNELS),
            .WIDTH    (WIDTH)
        ) u_field (
            .clk         (clk),
            .reset_n     (reset_n),
            .wr_en       (w_sel),
            .wr_data     (wr_data),
            .load_start  (load_start),
            .full        (load_full[f]),
            .overflow    (load_overflow[f]),
            .checksum    (load_checksum[f*WIDTH +: WIDTH]),
            .shadow_flat (w_shadow_flat[f*c_BANK_W +: c_BANK_W])
        );
    end

    // Commit FSM: a request coinciding with frame_sync commits immediately;
    // otherwise it arms and waits. Requests while armed are ignored.
    always_comb begin
        w_state_d = r_state_q;
        w_commit  = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (commit_req) begin
                    if (frame_sync) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (frame_sync) begin
                    w_commit  = 1'b1;
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q <= IDLE;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_done_q  <= w_commit;
        end
    end

    // The copy takes the registered shadow contents, so a write in the
    // commit cycle lands in shadow only and is not part of this commit.
    always_comb begin
        w_active_d = r_active_q;
        if (w_commit) begin
            w_active_d = w_shadow_flat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active_q <= '0;
        end else begin
            r_active_q <= w_active_d;
        end
    end

    assign commit_pending = (r_state_q == ARMED);
    assign commit_done    = r_done_q;
    assign active_out     = r_active_q;

endmodule : shadow_bank_loader
`default_nettype wire

// File: tb/tb_shadow_bank_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_shadow_bank_loader
// Description : Self-checking bench for shadow_bank_loader: directed
//               scenarios with literal expectations plus randomized traffic
//               compared every cycle against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shadow_bank_loader;

    localparam int C = 64;
    localparam int W = 16;
    localparam int F = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_field = '0;
    logic [W-1:0]     wr_data = '0;
    logic             load_start = 1'b0;
    logic             commit_req = 1'b0;
    logic             frame_sync = 1'b0;
    logic             commit_pending;
    logic             commit_done;
    logic [F-1:0]     load_full;
    logic [F-1:0]     load_overflow;
    logic [F*W-1:0]   load_checksum;
    logic [F*C*W-1:0] active_out;

    shadow_bank_loader #(
        .CHANNELS (C),
        .WIDTH    (W),
        .FIELDS   (F)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_field       (wr_field),
        .wr_data        (wr_data),
        .load_start     (load_start),
        .commit_req     (commit_req),
        .frame_sync     (frame_sync),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .load_full      (load_full),
        .load_overflow  (load_overflow),
        .load_checksum  (load_checksum),
        .active_out     (active_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model: what each bank holds and how many words it has taken.
    logic [W-1:0] m_sh  [F][C];
    logic [W-1:0] m_act [F][C];
    int           m_cnt [F];
    bit           m_full[F];
    bit           m_ovf [F];
    logic [W-1:0] m_sum [F];
    bit           m_pend;
    bit           m_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] act_word(input int f, input int c);
        return active_out[(f*C+c)*W +: W];
    endfunction

    // Apply the rules for one clock edge using the inputs present before it.
    task automatic model_edge();
        bit fire;
        if (!reset_n) begin
            for (int f = 0; f < F; f++) begin
                for (int c = 0; c < C; c++) begin
                    m_sh[f][c]  = '0;
                    m_act[f][c] = '0;
                end
                m_cnt[f] = 0; m_full[f] = 0; m_ovf[f] = 0; m_sum[f] = '0;
            end
            m_pend = 0;
            m_done = 0;
        end else begin
            fire   = frame_sync && (m_pend || commit_req);
            m_done = fire;
            if (fire) m_act = m_sh;
            if (m_pend) m_pend = !frame_sync;
            else        m_pend = commit_req && !frame_sync;
            for (int f = 0; f < F; f++) begin
                if (load_start) begin
                    m_cnt[f] = 0; m_full[f] = 0; m_ovf[f] = 0; m_sum[f] = '0;
                end
                if (wr_en && int'(wr_field) == f) begin
                    if (m_full[f]) begin
                        m_ovf[f] = 1;
                    end else begin
                        m_sh[f][m_cnt[f]] = wr_data;
                        m_sum[f] = m_sum[f] + wr_data;
                        m_cnt[f]++;
                        if (m_cnt[f] == C) begin
                            m_full[f] = 1;
                            m_cnt[f]  = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit we, input logic [1:0] fld, input logic [W-1:0] d,
                       input bit ls, input bit cr, input bit fs, input bit rn);
        wr_en = we; wr_field = fld; wr_data = d;
        load_start = ls; commit_req = cr; frame_sync = fs; reset_n = rn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 2'd0, '0, 0, 0, 0, 1);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [F-1:0]   ef;
            logic [F-1:0]   eo;
            logic [F*W-1:0] es;
            int             bad;
            for (int f = 0; f < F; f++) begin
                ef[f] = m_full[f];
                eo[f] = m_ovf[f];
`ifdef SHADOW_BANK_CHECKSUM_EN
                es[f*W +: W] = m_sum[f];
`else
                es[f*W +: W] = '0;
`endif
            end
            chk("commit_pending", 64'(commit_pending), 64'(m_pend));
            chk("commit_done", 64'(commit_done), 64'(m_done));
            chk("load_full", 64'(load_full), 64'(ef));
            chk("load_overflow", 64'(load_overflow), 64'(eo));
            chk("load_checksum", 64'(load_checksum), 64'(es));
            bad = -1;
            for (int f = 0; f < F; f++)
                for (int c = 0; c < C; c++)
                    if (bad < 0 && act_word(f, c) !== m_act[f][c]) bad = f*C + c;
            n_checks++;
            if (bad >= 0) begin
                n_errors++;
                $display("FAIL active_out entry %0d: got %0h expected %0h",
                         bad, act_word(bad / C, bad % C), m_act[bad / C][bad % C]);
            end
        end
    end

    initial begin
        // Reset
        cyc(0, 2'd0, '0, 0, 0, 0, 0);
        cyc(0, 2'd0, '0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("reset_pending", 64'(commit_pending), 64'h0);
        chk("reset_active_zero", 64'(|active_out), 64'h0);

        // Load field 0 with 0x0100+c
        cyc(0, 2'd0, '0, 1, 0, 0, 1);
        for (int c = 0; c < C; c++) cyc(1, 2'd0, W'(16'h0100 + c), 0, 0, 0, 1);
        chk("full_after_load", 64'(load_full), 64'b001);
        chk("active_before_commit", 64'(|active_out), 64'h0);

        // Armed commit, frame_sync 5 cycles later
        cyc(0, 2'd0, '0, 0, 1, 0, 1);
        chk("armed_pending", 64'(commit_pending), 64'h1);
        for (int i = 0; i < 4; i++) idle();
        cyc(0, 2'd0, '0, 0, 0, 1, 1);
        chk("commit_done_pulse", 64'(commit_done), 64'h1);
        chk("pending_dropped", 64'(commit_pending), 64'h0);
        chk("active_f0_c0", 64'(act_word(0, 0)), 64'h0100);
        chk("active_f0_c63", 64'(act_word(0, 63)), 64'h013F);

        // Field 1 overflow
        cyc(0, 2'd0, '0, 1, 0, 0, 1);
        for (int c = 0; c < C; c++) cyc(1, 2'd1, W'(16'h2000 + c), 0, 0, 0, 1);
        cyc(1, 2'd1, 16'hBEEF, 0, 0, 0, 1);
        chk("overflow_set", 64'(load_overflow), 64'b010);
        cyc(0, 2'd0, '0, 1, 0, 0, 1);
        chk("overflow_cleared", 64'(load_overflow), 64'b000);
        cyc(0, 2'd0, '0, 0, 1, 1, 1);
        chk("f1_c0_not_overwritten", 64'(act_word(1, 0)), 64'h2000);

        // Write in the commit cycle is excluded from that commit
        cyc(1, 2'd2, 16'h5555, 0, 0, 0, 1);
        cyc(0, 2'd0, '0, 0, 1, 1, 1);
        cyc(0, 2'd0, '0, 1, 0, 0, 1);
        cyc(1, 2'd2, 16'h1234, 0, 1, 1, 1);
        chk("commit_cycle_write_excluded", 64'(act_word(2, 0)), 64'h5555);
        cyc(0, 2'd0, '0, 0, 1, 1, 1);
        chk("second_commit_has_write", 64'(act_word(2, 0)), 64'h1234);

        // Reset aborts an armed commit
        cyc(0, 2'd0, '0, 0, 1, 0, 1);
        cyc(0, 2'd0, '0, 0, 0, 0, 0);
        cyc(0, 2'd0, '0, 0, 0, 1, 1);
        chk("abort_no_done", 64'(commit_done), 64'h0);
        chk("abort_no_pending", 64'(commit_pending), 64'h0);
        chk("abort_active_zero", 64'(|active_out), 64'h0);

        // Checksum wrap
        cyc(0, 2'd0, '0, 1, 0, 0, 1);
        cyc(1, 2'd0, 16'hFFFF, 0, 0, 0, 1);
        cyc(1, 2'd0, 16'h0002, 0, 0, 0, 1);
`ifdef SHADOW_BANK_CHECKSUM_EN
        chk("checksum_wrap", 64'(load_checksum[W-1:0]), 64'h0001);
`else
        chk("checksum_tied_zero", 64'(load_checksum), 64'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 99) < 60,
                2'($urandom_range(0, 3)),
                W'($urandom),
                $urandom_range(0, 999) < 3,
                $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 8,
                !($urandom_range(0, 999) < 4));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_shadow_bank_loader
`default_nettype wire
